fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared fetch FSM encoding and instruction-field constants
// Rev 1.0 : initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  OP_HALT = 6'b111111;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          OPC_MSB = 31;
  localparam int          OPC_LSB = 26;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC holder, imem req/ack fetch and valid/ready delivery to decode
// Rev 1.0 : initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             decode_ready,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t     r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_instr, r_instr_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic             r_imem_req, r_instr_valid, r_halted;
  logic             w_capture, w_handshake;
  logic [31:0]      w_target;

  assign w_target = branch_target & ~32'd3;

  // Redirect is checked first in every live state so it beats ack and halt.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (branch_taken) w_pc_nxt = w_target;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          w_pc_nxt = w_target;
        end else if (imem_ack) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_handshake = decode_ready;
        if (branch_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else if (decode_ready) begin
          w_state_nxt = (opcode_of(r_instr) == OP_HALT) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_fetch_count <= '0;
    end else begin
      r_imem_req    <= (w_state_nxt == ST_FETCH);
      r_instr_valid <= (w_state_nxt == ST_HOLD);
      r_halted      <= (w_state_nxt == ST_HALT);
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_handshake) r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table, reset/wrap sequences, random scoreboard
// Rev 1.0 : initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0, ready = 1'b0, br = 1'b0;
  logic [31:0] rdata = 32'd0, tgt = 32'd0;
  logic        req, valid, hlt;
  logic [31:0] addr, ins, ipc;
  logic [15:0] cnt;

  // Second instance exercises PC wrap-around; its memory always acks with 0.
  logic        w_ack = 1'b1, w_ready = 1'b1, w_br = 1'b0;
  logic [31:0] w_rdata = 32'd0, w_tgt = 32'd0;
  logic        w_req, w_valid, w_hlt;
  logic [31:0] w_addr, w_ins, w_ipc;
  logic [15:0] w_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .instr_valid(valid), .decode_ready(ready), .instr(ins),
    .instr_pc(ipc), .branch_taken(br), .branch_target(tgt), .halted(hlt),
    .fetch_count(cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .instr_valid(w_valid), .decode_ready(w_ready), .instr(w_ins),
    .instr_pc(w_ipc), .branch_taken(w_br), .branch_target(w_tgt), .halted(w_hlt),
    .fetch_count(w_cnt)
  );

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic a, input logic [31:0] d, input logic r,
                              input logic b, input logic [31:0] t, input logic eq,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic eh, input logic [15:0] ec);
    vec_t v;
    v = '{a, d, r, b, t, eq, ea, ev, ei, ep, eh, ec};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ack = 1'b0; ready = 1'b0; br = 1'b0; rdata = 32'd0; tgt = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state: what decode should see, expressed as contract flags.
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halt, m_started;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_ipc = 32'd0;
    m_valid = 1'b0; m_halt = 1'b0; m_started = 1'b0; m_cnt = 16'd0;
  endtask

  initial begin
    logic m_req, hs;
    int   halt_cycles;

    // ack/rdata/ready/br/tgt || req/addr/valid/instr/ipc/halted/count
    tbl[0]  = mk(0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   0, 32'h0,         32'h0,   0, 0);
    tbl[1]  = mk(1, 32'h100,       0, 0, 32'h0,   1, 32'h0,   0, 32'h0,         32'h0,   0, 0);
    tbl[2]  = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h4,   1, 32'h100,       32'h0,   0, 0);
    tbl[3]  = mk(1, 32'h104,       0, 0, 32'h0,   1, 32'h4,   0, 32'h100,       32'h0,   0, 1);
    tbl[4]  = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h8,   1, 32'h104,       32'h4,   0, 1);
    tbl[5]  = mk(1, 32'h108,       0, 0, 32'h0,   1, 32'h8,   0, 32'h104,       32'h4,   0, 2);
    tbl[6]  = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'hC,   1, 32'h108,       32'h8,   0, 2);
    tbl[7]  = mk(0, 32'h0,         0, 0, 32'h0,   1, 32'hC,   0, 32'h108,       32'h8,   0, 3);
    tbl[8]  = mk(0, 32'h0,         0, 0, 32'h0,   1, 32'hC,   0, 32'h108,       32'h8,   0, 3);
    tbl[9]  = mk(0, 32'h0,         0, 0, 32'h0,   1, 32'hC,   0, 32'h108,       32'h8,   0, 3);
    tbl[10] = mk(1, 32'h10C,       0, 0, 32'h0,   1, 32'hC,   0, 32'h108,       32'h8,   0, 3);
    tbl[11] = mk(0, 32'h0,         0, 0, 32'h0,   0, 32'h10,  1, 32'h10C,       32'hC,   0, 3);
    tbl[12] = mk(1, 32'hBAD,       0, 0, 32'h0,   0, 32'h10,  1, 32'h10C,       32'hC,   0, 3);
    tbl[13] = mk(0, 32'h0,         0, 0, 32'h0,   0, 32'h10,  1, 32'h10C,       32'hC,   0, 3);
    tbl[14] = mk(0, 32'h0,         0, 0, 32'h0,   0, 32'h10,  1, 32'h10C,       32'hC,   0, 3);
    tbl[15] = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h10,  1, 32'h10C,       32'hC,   0, 3);
    tbl[16] = mk(1, 32'h110,       0, 1, 32'h43,  1, 32'h10,  0, 32'h10C,       32'hC,   0, 4);
    tbl[17] = mk(1, 32'h140,       0, 0, 32'h0,   1, 32'h40,  0, 32'h10C,       32'hC,   0, 4);
    tbl[18] = mk(0, 32'h0,         1, 1, 32'h201, 0, 32'h44,  1, 32'h140,       32'h40,  0, 4);
    tbl[19] = mk(1, 32'hFC00_0000, 0, 0, 32'h0,   1, 32'h200, 0, 32'h140,       32'h40,  0, 5);
    tbl[20] = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h204, 1, 32'hFC00_0000, 32'h200, 0, 5);
    tbl[21] = mk(0, 32'h0,         0, 1, 32'h80,  0, 32'h204, 0, 32'hFC00_0000, 32'h200, 1, 6);
    tbl[22] = mk(1, 32'hDEAD,      0, 0, 32'h0,   0, 32'h204, 0, 32'hFC00_0000, 32'h200, 1, 6);
    tbl[23] = mk(0, 32'h0,         1, 0, 32'h0,   0, 32'h204, 0, 32'hFC00_0000, 32'h200, 1, 6);

    do_reset();
    for (int k = 0; k < 24; k++) begin
      ack = tbl[k].ack; rdata = tbl[k].rdata; ready = tbl[k].ready;
      br = tbl[k].br;   tgt = tbl[k].tgt;
      chk($sformatf("v%0d req", k),    {31'd0, req},   {31'd0, tbl[k].e_req});
      chk($sformatf("v%0d addr", k),   addr,           tbl[k].e_addr);
      chk($sformatf("v%0d valid", k),  {31'd0, valid}, {31'd0, tbl[k].e_valid});
      chk($sformatf("v%0d instr", k),  ins,            tbl[k].e_instr);
      chk($sformatf("v%0d ipc", k),    ipc,            tbl[k].e_ipc);
      chk($sformatf("v%0d halted", k), {31'd0, hlt},   {31'd0, tbl[k].e_halt});
      chk($sformatf("v%0d count", k),  {16'd0, cnt},   {16'd0, tbl[k].e_cnt});
      if (k == 1) chk("wrap first addr", w_addr, 32'hFFFF_FFFC);
      if (k == 3) begin
        chk("wrap second req", {31'd0, w_req}, 32'd1);
        chk("wrap second addr", w_addr, 32'h0000_0000);
      end
      @(negedge clk);
    end

    // Asynchronous reset while halted, then a stale ack through IDLE.
    #2;
    rst_n = 1'b0; ack = 1'b1; rdata = 32'h0000_0ABC; ready = 1'b0; br = 1'b0;
    #1;
    chk("async rst halted", {31'd0, hlt}, 32'd0);
    chk("async rst count",  {16'd0, cnt}, 32'd0);
    chk("async rst instr",  ins,  32'd0);
    chk("async rst ipc",    ipc,  32'd0);
    chk("async rst addr",   addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("idle stale ack req",   {31'd0, req},   32'd0);
    chk("idle stale ack valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("refetch req",  {31'd0, req}, 32'd1);
    chk("refetch addr", addr, 32'd0);
    chk("refetch valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("refetch instr valid", {31'd0, valid}, 32'd1);
    chk("refetch instr", ins, 32'h0000_0ABC);
    chk("refetch ipc",   ipc, 32'd0);

    // Randomized episodes against the contract-level model.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      model_reset();
      halt_cycles = 0;
      for (int c = 0; c < 400 && halt_cycles < 4; c++) begin
        m_req = m_started && !m_valid && !m_halt;
        chk($sformatf("r%0d.%0d req", ep, c),    {31'd0, req},   {31'd0, m_req});
        chk($sformatf("r%0d.%0d valid", ep, c),  {31'd0, valid}, {31'd0, m_valid});
        chk($sformatf("r%0d.%0d halted", ep, c), {31'd0, hlt},   {31'd0, m_halt});
        chk($sformatf("r%0d.%0d count", ep, c),  {16'd0, cnt},   {16'd0, m_cnt});
        if (m_req) chk($sformatf("r%0d.%0d addr", ep, c), addr, m_pc);
        if (m_valid) begin
          chk($sformatf("r%0d.%0d instr", ep, c), ins, m_instr);
          chk($sformatf("r%0d.%0d ipc", ep, c),   ipc, m_ipc);
        end
        if (m_halt) halt_cycles++;

        ack   = ($urandom_range(0, 2) == 0);
        rdata = $urandom;
        if ($urandom_range(0, 15) == 0) rdata[31:26] = 6'b111111;
        ready = ($urandom_range(0, 3) != 0);
        br    = ($urandom_range(0, 11) == 0);
        tgt   = $urandom;

        @(posedge clk);
        if (!m_started) begin
          m_started = 1'b1;
          if (br) m_pc = tgt & ~32'd3;
        end else if (!m_halt) begin
          hs = m_valid && ready;
          if (hs) m_cnt = m_cnt + 16'd1;
          if (br) begin
            m_pc = tgt & ~32'd3;
            m_valid = 1'b0;
          end else if (m_req && ack) begin
            m_instr = rdata;
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
          end else if (hs) begin
            m_valid = 1'b0;
            if (m_instr[31:26] == 6'b111111) m_halt = 1'b1;
          end
        end
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
